// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared funct3 encodings, FSM state type and helpers for the MDU.
// Rev    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic mdu_is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module : mdu_if
// Brief  : Request/response handshake bundle between the core and the MDU.
// Rev    : 1.0 - initial release
// ============================================================================
interface mdu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [ADDR_WIDTH-1:0] rd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] rd_out;

    modport master (
        output in_valid, funct3, src1, src2, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out
    );

    modport slave (
        input  in_valid, funct3, src1, src2, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out
    );
endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module : mdu_div_core
// Brief  : Restoring divider on unsigned magnitudes, one quotient bit per step.
// Rev    : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic                  step,
    input  wire logic [DATA_WIDTH-1:0] dividend,
    input  wire logic [DATA_WIDTH-1:0] divisor,
    output logic      [DATA_WIDTH-1:0] quotient,
    output logic      [DATA_WIDTH-1:0] remainder
);

    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_div;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_fits;
    logic [DATA_WIDTH-1:0] w_rem_nxt;
    logic [DATA_WIDTH-1:0] w_quo_nxt;

    // Partial remainder is always below the divisor, so bit DATA_WIDTH of the
    // difference is a reliable borrow flag.
    always_comb begin
        w_shift   = {r_rem, r_quo[DATA_WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_div};
        w_fits    = ~w_diff[DATA_WIDTH];
        w_rem_nxt = w_fits ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
        w_quo_nxt = {r_quo[DATA_WIDTH-2:0], w_fits};
    end

    // Outputs reflect the state once the step taken this cycle commits.
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
        end else if (step) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module : mdu_iterative
// Brief  : Iterative RV32M multiply/divide unit with valid/ready handshake.
//          Define MDU_FAST_MUL_EN for single-cycle multiplies.
// Rev    : 1.0 - initial release
// ============================================================================
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input wire logic clk,
    input wire logic rst,
    mdu_if.slave     bus
);

    localparam int                    CW        = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mdu_state_t              r_state;
    logic [2:0]              r_funct3;
    logic [ADDR_WIDTH-1:0]   r_rd;
    logic                    r_neg;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic [DATA_WIDTH-1:0]   r_result;

    logic                    w_is_div;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic                    w_neg;
    logic [DATA_WIDTH-1:0]   w_a_mag;
    logic [DATA_WIDTH-1:0]   w_b_mag;
    logic                    w_div_zero;
    logic                    w_ovf;
    logic [DATA_WIDTH-1:0]   w_special_val;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [2*DATA_WIDTH-1:0] w_prod_nxt;
    logic [DATA_WIDTH-1:0]   w_quo;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic                    w_accept;
`ifdef MDU_FAST_MUL_EN
    logic [2*DATA_WIDTH-1:0] w_fast_prod;
`endif

    function automatic logic [DATA_WIDTH-1:0] fix_mul(input logic [2*DATA_WIDTH-1:0] prod,
                                                      input logic neg, input logic [2:0] f3);
        logic [2*DATA_WIDTH-1:0] p;
        p = neg ? -prod : prod;
        return (f3 == MDU_MUL) ? p[DATA_WIDTH-1:0] : p[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fix_div(input logic [DATA_WIDTH-1:0] q,
                                                      input logic [DATA_WIDTH-1:0] r,
                                                      input logic neg, input logic [2:0] f3);
        logic [DATA_WIDTH-1:0] v;
        v = f3[1] ? r : q;
        return neg ? -v : v;
    endfunction

    // Operand signedness: MULH/DIV/REM signed both, MULHSU only src1.
    always_comb begin
        w_is_div   = mdu_is_div(bus.funct3);
        w_a_neg    = bus.src1[DATA_WIDTH-1] &
                     ((bus.funct3 == MDU_MULH) | (bus.funct3 == MDU_MULHSU) |
                      (bus.funct3 == MDU_DIV)  | (bus.funct3 == MDU_REM));
        w_b_neg    = bus.src2[DATA_WIDTH-1] &
                     ((bus.funct3 == MDU_MULH) | (bus.funct3 == MDU_DIV) |
                      (bus.funct3 == MDU_REM));
        w_a_mag    = w_a_neg ? -bus.src1 : bus.src1;
        w_b_mag    = w_b_neg ? -bus.src2 : bus.src2;
        w_neg      = (bus.funct3 == MDU_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = (bus.src2 == '0);
        w_ovf      = bus.funct3[2] & ~bus.funct3[0] &
                     (bus.src1 == c_INT_MIN) & (bus.src2 == '1);
        w_special_val = '0;
        if (w_div_zero)
            w_special_val = bus.funct3[1] ? bus.src1 : '1;
        else if (!bus.funct3[1])
            w_special_val = c_INT_MIN;
    end

    // Shift-add step: add multiplicand into the upper half, then shift right.
    always_comb begin
        w_mul_sum  = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]} +
                     (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_nxt = {w_mul_sum, r_prod[DATA_WIDTH-1:1]};
    end

`ifdef MDU_FAST_MUL_EN
    assign w_fast_prod = {{DATA_WIDTH{1'b0}}, w_a_mag} * {{DATA_WIDTH{1'b0}}, w_b_mag};
`endif

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

    mdu_div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_accept),
        .step      (r_state == ST_CALC),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_funct3 <= MDU_MUL;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_funct3 <= bus.funct3;
                        r_rd     <= bus.rd_in;
                        r_neg    <= w_neg;
                        r_count  <= '0;
                        r_mcand  <= w_a_mag;
                        r_prod   <= {{DATA_WIDTH{1'b0}}, w_b_mag};
                        if (w_is_div && (w_div_zero || w_ovf)) begin
                            r_result <= w_special_val;
                            r_state  <= ST_DONE;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_result <= fix_mul(w_fast_prod, w_neg, bus.funct3);
                            r_state  <= ST_DONE;
                        end
`endif
                        else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_prod  <= w_prod_nxt;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(DATA_WIDTH-1)) begin
                        r_result <= mdu_is_div(r_funct3) ? fix_div(w_quo, w_rem, r_neg, r_funct3)
                                                         : fix_mul(w_prod_nxt, r_neg, r_funct3);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.rd_out    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module : tb_mdu_iterative
// Brief  : Directed plus randomized bench for mdu_iterative against an
//          arithmetic reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mdu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    mdu_iterative #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] ua, ub, pu;
        int          ia, ib, iq;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        r  = '0;
        case (f)
            3'd0: begin pu = ua * ub; r = pu[31:0];  end
            3'd1: begin p  = sa * sb; r = p[63:32];  end
            3'd2: begin p  = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin pu = ua * ub; r = pu[63:32]; end
            default: begin
                if (b == 32'd0)
                    r = f[1] ? a : 32'hFFFF_FFFF;
                else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = f[1] ? 32'd0 : 32'h8000_0000;
                else if (f == 3'd4) begin iq = ia / ib; r = iq; end
                else if (f == 3'd6) begin iq = ia % ib; r = iq; end
                else if (f == 3'd5) r = a / b;
                else                r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
`ifdef MDU_FAST_MUL_EN
        if (!f[2])
            return 0;
`endif
        return 32;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges counted after the accept edge until out_valid is seen.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold, input string tag);
        logic [31:0] exp_res;
        int          exp_lat;
        int          n;
        exp_res = ref_model(f, a, b);
        exp_lat = ref_latency(f, a, b);
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.src1     = a;
        bus.src2     = b;
        bus.rd_in    = rd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
        bus.rd_in    = 5'($urandom);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        if (bus.out_valid !== 1'b1) return;
        check({tag, ".result"}, 64'(bus.result), 64'(exp_res));
        check({tag, ".rd_out"}, 64'(bus.rd_out), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_result"}, 64'(bus.result), 64'(exp_res));
            check({tag, ".hold_rd"}, 64'(bus.rd_out), 64'(rd));
            check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, ".hold_out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".post_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, ".post_out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'd0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.rd_in     = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.result", 64'(bus.result), 64'd0);
        check("reset.rd_out", 64'(bus.rd_out), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 0, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, "rem");
        run_op(3'd5, 32'd7, 32'd2, 5'd9, 0, "divu");
        run_op(3'd7, 32'd7, 32'd2, 5'd10, 0, "remu");
        run_op(3'd4, 32'd5, 32'd0, 5'd11, 0, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, 5'd12, 0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, "rem_ovf");
        run_op(3'd4, 32'd1000, 32'd7, 5'd17, 5, "backpressure");
        run_op(3'd0, 32'd3, 32'd9, 5'd0, 0, "rd_zero");

        // Reset ten cycles into a divide discards it.
        bus.in_valid = 1'b1;
        bus.funct3   = 3'd4;
        bus.src1     = 32'd100;
        bus.src2     = 32'd7;
        bus.rd_in    = 5'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midreset.busy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset.in_ready", 64'(bus.in_ready), 64'd1);
        check("midreset.out_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midreset.no_valid", 64'(bus.out_valid), 64'd0);
        end
        run_op(3'd6, 32'd100, 32'd7, 5'd21, 0, "after_reset");

        for (int k = 0; k < 24; k++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            run_op(rf, ra, rb, 5'($urandom), $urandom_range(0, 2), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
